mem_arbiter: RTL

// Two-port round-robin arbiter in front of the single mem_cntrl request port.

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single mem_cntrl request port.
// Latches the winning command, sequences the rdy/cplt handshake and guards it with a watchdog.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic                  r0_r_en,
    input  logic                  r0_w_en,
    output logic                  r0_cplt,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_err,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic                  r1_r_en,
    input  logic                  r1_w_en,
    output logic                  r1_cplt,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    input  logic                  mem_rdy,
    input  logic                  mem_cplt,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  grant_id
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  is_read, is_read_nxt;
    logic [WD_W-1:0]       wd_cnt, wd_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  r_en_nxt, w_en_nxt, grant_nxt, busy_nxt;
    logic                  cplt0_nxt, cplt1_nxt, err0_nxt, err1_nxt;
    logic [DATA_WIDTH-1:0] rdata0_nxt, rdata1_nxt;
    logic                  req0, req1, sel1, sel_read, wd_hit;
    logic                  fin, fin_err;
    logic [DATA_WIDTH-1:0] fin_data;

    assign req0     = r0_r_en | r0_w_en;
    assign req1     = r1_r_en | r1_w_en;
    // r1 wins when alone, or on a tie when r0 was served last
    assign sel1     = req1 & (~req0 | ~last_grant);
    assign sel_read = sel1 ? r1_r_en : r0_r_en;
    assign wd_hit   = (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            is_read     <= 1'b0;
            wd_cnt      <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_r_en    <= 1'b0;
            mem_w_en    <= 1'b0;
            grant_id    <= 1'b0;
            busy        <= 1'b0;
            r0_cplt     <= 1'b0;
            r1_cplt     <= 1'b0;
            r0_err      <= 1'b0;
            r1_err      <= 1'b0;
            r0_rdata    <= '0;
            r1_rdata    <= '0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            is_read     <= is_read_nxt;
            wd_cnt      <= wd_nxt;
            mem_addr    <= addr_nxt;
            mem_data_in <= data_nxt;
            mem_r_en    <= r_en_nxt;
            mem_w_en    <= w_en_nxt;
            grant_id    <= grant_nxt;
            busy        <= busy_nxt;
            r0_cplt     <= cplt0_nxt;
            r1_cplt     <= cplt1_nxt;
            r0_err      <= err0_nxt;
            r1_err      <= err1_nxt;
            r0_rdata    <= rdata0_nxt;
            r1_rdata    <= rdata1_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        is_read_nxt    = is_read;
        wd_nxt         = wd_cnt;
        addr_nxt       = mem_addr;
        data_nxt       = mem_data_in;
        r_en_nxt       = mem_r_en;
        w_en_nxt       = mem_w_en;
        grant_nxt      = grant_id;
        cplt0_nxt      = 1'b0;
        cplt1_nxt      = 1'b0;
        err0_nxt       = 1'b0;
        err1_nxt       = 1'b0;
        rdata0_nxt     = '0;
        rdata1_nxt     = '0;
        fin            = 1'b0;
        fin_err        = 1'b0;
        fin_data       = '0;

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant_nxt      = sel1;
                    last_grant_nxt = sel1;
                    addr_nxt       = sel1 ? r1_addr : r0_addr;
                    data_nxt       = sel1 ? r1_wdata : r0_wdata;
                    is_read_nxt    = sel_read;
                    r_en_nxt       = sel_read;
                    w_en_nxt       = ~sel_read;
                    wd_nxt         = '0;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                wd_nxt = wd_cnt + WD_W'(1);
                if (wd_hit) begin
                    r_en_nxt  = 1'b0;
                    w_en_nxt  = 1'b0;
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    state_nxt = DONE;
                end else if (mem_rdy) begin
                    r_en_nxt  = 1'b0;
                    w_en_nxt  = 1'b0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                wd_nxt = wd_cnt + WD_W'(1);
                // real completion beats a coincident timeout
                if (mem_cplt) begin
                    fin       = 1'b1;
                    fin_data  = is_read ? mem_data_out : '0;
                    state_nxt = DONE;
                end else if (wd_hit) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (fin) begin
            if (grant_id) begin
                cplt1_nxt  = 1'b1;
                err1_nxt   = fin_err;
                rdata1_nxt = fin_data;
            end else begin
                cplt0_nxt  = 1'b1;
                err0_nxt   = fin_err;
                rdata0_nxt = fin_data;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
